// File: rtl/nn_pkg.sv
// Shared constants for the NN stimulus transmitter: protocol geometry, FSM
// state codes and the pipeline tag that says which NN bus a ROM word feeds.
package nn_pkg;
    localparam int DW      = 32;
    localparam int N_W1    = 12;
    localparam int N_W2    = 3;
    localparam int N_D     = 4;
    localparam int AW      = 10;
    localparam int MAX_LAT = 255;

    localparam logic [31:0] FP_ONE = 32'h3F80_0000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WGT  = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_DAT  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    typedef enum logic [1:0] {
        K_W1 = 2'd0,
        K_W2 = 2'd1,
        K_D  = 2'd2,
        K_T  = 2'd3
    } kind_t;
endpackage

// File: rtl/nn_rom_fetch.sv
// ROM address register plus two-stage tag pipeline: a request issued in cycle c
// shows its word on the matching NN bus in cycle c+3 (rom_addr in c+1).
module nn_rom_fetch import nn_pkg::*; #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [1:0]    kind,
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_rdata,
    output logic          in_valid_w1,
    output logic [DW-1:0] weight1,
    output logic          in_valid_w2,
    output logic [DW-1:0] weight2,
    output logic          in_valid_d,
    output logic [DW-1:0] data_point,
    output logic          in_valid_t,
    output logic [DW-1:0] target
);
    logic       vld_a;
    logic [1:0] kind_a;
    logic       vld_r;
    logic [1:0] kind_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr    <= '0;
            vld_a       <= 1'b0;
            kind_a      <= 2'd0;
            vld_r       <= 1'b0;
            kind_r      <= 2'd0;
            in_valid_w1 <= 1'b0;
            in_valid_w2 <= 1'b0;
            in_valid_d  <= 1'b0;
            in_valid_t  <= 1'b0;
            weight1     <= '0;
            weight2     <= '0;
            data_point  <= '0;
            target      <= '0;
        end else begin
            vld_a  <= req;
            kind_a <= kind;
            if (req) rom_addr <= addr;
            vld_r  <= vld_a;
            kind_r <= kind_a;

            in_valid_w1 <= vld_r && (kind_r == K_W1);
            in_valid_w2 <= vld_r && (kind_r == K_W2);
            in_valid_d  <= vld_r && (kind_r == K_D);
            in_valid_t  <= vld_r && (kind_r == K_T);
            // buses only load with their own beat so they hold between beats
            if (vld_r && kind_r == K_W1) weight1    <= rom_rdata;
            if (vld_r && kind_r == K_W2) weight2    <= rom_rdata;
            if (vld_r && kind_r == K_D)  data_point <= rom_rdata;
            if (vld_r && kind_r == K_T)  target     <= rom_rdata;
        end
    end
endmodule

// File: rtl/nn_stim_tx.sv
// Sequences a weight set and num_smp samples from the pattern ROM into NN and
// captures each NN result for the host.
//   state | meaning
//   IDLE  | waiting for start
//   WGT   | issue N_W1 weight1 then N_W2 weight2 reads
//   GAP   | one cycle with no read ahead of each sample
//   DAT   | issue N_D data reads then the target read
//   WAIT  | drain pipeline, then wait for out_valid or latency timeout
//   FIN   | drain pipeline, pulse done
module nn_stim_tx import nn_pkg::*; #(
    parameter int DW      = nn_pkg::DW,
    parameter int N_W1    = nn_pkg::N_W1,
    parameter int N_W2    = nn_pkg::N_W2,
    parameter int N_D     = nn_pkg::N_D,
    parameter int AW      = nn_pkg::AW,
    parameter int MAX_LAT = nn_pkg::MAX_LAT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    num_smp,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_rdata,
    output logic          in_valid_w1,
    output logic [DW-1:0] weight1,
    output logic          in_valid_w2,
    output logic [DW-1:0] weight2,
    output logic          in_valid_d,
    output logic [DW-1:0] data_point,
    output logic          in_valid_t,
    output logic [DW-1:0] target,
    input  logic          out_valid,
    input  logic [DW-1:0] out,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic [7:0]    res_idx,
    output logic          busy,
    output logic          done,
    output logic          err_tout
);
    localparam int BC_W = $clog2(N_W1 + N_W2 + N_D + 1);
    localparam logic [BC_W-1:0] BC_WGT   = BC_W'(N_W1 + N_W2 - 1);
    localparam logic [BC_W-1:0] BC_W2    = BC_W'(N_W2);
    localparam logic [BC_W-1:0] BC_DAT   = BC_W'(N_D);
    localparam logic [BC_W-1:0] BC_DRAIN = BC_W'(2);

    // WAIT is entered two cycles before the target beat reaches the port, so the
    // load covers that lag and the count hits zero MAX_LAT-1 cycles after the beat.
    localparam int LAT_W = $clog2(MAX_LAT + 2);
    localparam logic [LAT_W-1:0] WAIT_LOAD = LAT_W'(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_OPEN  = LAT_W'(MAX_LAT - 1);

    logic [2:0]       state;
    logic [AW-1:0]    addr;
    logic [BC_W-1:0]  beat_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic [7:0]       num_q;
    logic [7:0]       smp;
    logic             req;
    logic [1:0]       kind;

    always_comb begin
        req  = 1'b0;
        kind = K_W1;
        if (state == ST_WGT) begin
            req  = 1'b1;
            kind = (beat_cnt >= BC_W2) ? K_W1 : K_W2;
        end else if (state == ST_DAT) begin
            req  = 1'b1;
            kind = (beat_cnt == '0) ? K_T : K_D;
        end
    end

    nn_rom_fetch #(.DW(DW), .AW(AW)) u_fetch (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .kind        (kind),
        .addr        (addr),
        .rom_addr    (rom_addr),
        .rom_rdata   (rom_rdata),
        .in_valid_w1 (in_valid_w1),
        .weight1     (weight1),
        .in_valid_w2 (in_valid_w2),
        .weight2     (weight2),
        .in_valid_d  (in_valid_d),
        .data_point  (data_point),
        .in_valid_t  (in_valid_t),
        .target      (target)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            beat_cnt  <= '0;
            lat_cnt   <= '0;
            num_q     <= 8'd0;
            smp       <= 8'd0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_tout  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_WGT;
                        busy     <= 1'b1;
                        err_tout <= 1'b0;
                        num_q    <= num_smp;
                        smp      <= 8'd0;
                        addr     <= '0;
                        beat_cnt <= BC_WGT;
                    end
                end
                ST_WGT: begin
                    addr <= addr + 1'b1;
                    if (beat_cnt == '0) begin
                        if (num_q == 8'd0) begin
                            state    <= ST_FIN;
                            beat_cnt <= BC_DRAIN;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    state    <= ST_DAT;
                    beat_cnt <= BC_DAT;
                end
                ST_DAT: begin
                    addr <= addr + 1'b1;
                    if (beat_cnt == '0) begin
                        state   <= ST_WAIT;
                        lat_cnt <= WAIT_LOAD;
                    end else begin
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    // a result on the final count still wins over the timeout
                    if (out_valid && lat_cnt < LAT_OPEN) begin
                        res_valid <= 1'b1;
                        res_data  <= out;
                        res_idx   <= smp;
                        smp       <= smp + 8'd1;
                        if (smp + 8'd1 == num_q) begin
                            state    <= ST_FIN;
                            beat_cnt <= '0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else if (lat_cnt == '0) begin
                        err_tout <= 1'b1;
                        state    <= ST_FIN;
                        beat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_FIN: begin
                    if (beat_cnt == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        beat_cnt <= beat_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nn_stim_tx.sv
// Bench for nn_stim_tx: sync-read ROM model, NN responder with per-sample
// latency, and a beat logger compared against the ROM map and answer tables.
module tb_nn_stim_tx;
    import nn_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_smp = 8'd0;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata = 32'd0;
    logic        in_valid_w1, in_valid_w2, in_valid_d, in_valid_t;
    logic [31:0] weight1, weight2, data_point, target;
    logic        out_valid = 1'b0;
    logic [31:0] out = 32'd0;
    logic        res_valid, busy, done, err_tout;
    logic [31:0] res_data;
    logic [7:0]  res_idx;

    nn_stim_tx dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_smp(num_smp),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .in_valid_w1(in_valid_w1), .weight1(weight1),
        .in_valid_w2(in_valid_w2), .weight2(weight2),
        .in_valid_d(in_valid_d), .data_point(data_point),
        .in_valid_t(in_valid_t), .target(target),
        .out_valid(out_valid), .out(out),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .busy(busy), .done(done), .err_tout(err_tout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rom [0:1023];
    always @(posedge clk) rom_rdata <= rom[rom_addr];

    int          vectors = 0;
    int          miscompares = 0;
    int          run_id = 0;
    int          lat_arr [0:15];
    logic [31:0] ans_arr [0:15];
    bit          spur_on = 1'b0;

    // NN responder: out_valid lat cycles after each target beat; lat 0 = never
    int m_run = 0, m_smp = 0, m_cd = 0;
    always @(negedge clk) begin
        if (m_run != run_id) begin
            m_run = run_id; m_smp = 0; m_cd = 0;
        end
        out_valid = 1'b0;
        if (spur_on && (in_valid_w1 || in_valid_w2 || in_valid_d || in_valid_t)) begin
            out_valid = 1'b1; out = 32'hDEAD_BEEF;
        end
        if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) begin out_valid = 1'b1; out = ans_arr[m_smp-1]; end
        end
        if (rst_n && in_valid_t && m_smp < 16) begin
            m_cd = lat_arr[m_smp];
            m_smp++;
        end
    end

    logic [31:0] w1_q[$], w2_q[$], d_q[$], t_q[$], rd_q[$];
    int w1_c[$], w2_c[$], d_c[$], t_c[$], gap_q[$], ri_q[$], rc_q[$];
    int mon_run = 0, done_n = 0, done_c = -1, err_c = -1, overlap = 0, idle_run = 0, mon_nv;
    bit prev_d = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (mon_run != run_id) begin
            mon_run = run_id;
            w1_q.delete(); w2_q.delete(); d_q.delete(); t_q.delete(); rd_q.delete();
            w1_c.delete(); w2_c.delete(); d_c.delete(); t_c.delete();
            gap_q.delete(); ri_q.delete(); rc_q.delete();
            done_n = 0; done_c = -1; err_c = -1; overlap = 0; idle_run = 0; prev_d = 1'b0;
        end
        if (rst_n) begin
            mon_nv = int'(in_valid_w1) + int'(in_valid_w2) + int'(in_valid_d) + int'(in_valid_t);
            if (mon_nv > 1) overlap++;
            if (in_valid_w1) begin w1_q.push_back(weight1); w1_c.push_back(cyc); end
            if (in_valid_w2) begin w2_q.push_back(weight2); w2_c.push_back(cyc); end
            if (in_valid_d) begin d_q.push_back(data_point); d_c.push_back(cyc); end
            if (in_valid_t) begin t_q.push_back(target); t_c.push_back(cyc); end
            if (in_valid_d && !prev_d) gap_q.push_back(idle_run);
            idle_run = (mon_nv == 0) ? idle_run + 1 : 0;
            prev_d = in_valid_d;
            if (res_valid) begin rd_q.push_back(res_data); ri_q.push_back(int'(res_idx)); rc_q.push_back(cyc); end
            if (done) begin done_n++; done_c = cyc; end
            if (err_tout && !prev_err) err_c = cyc;
        end
        prev_err = err_tout;
    end

    task automatic pulse_start(input int n);
        @(negedge clk); start = 1'b1; num_smp = 8'(n);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL %s_done: no done within %0d cycles", tag, budget); end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_valid_w1, in_valid_w2, in_valid_d, in_valid_t, busy, done, res_valid, err_tout} !== 8'h00) begin
            miscompares++; $display("FAIL reset_ctrl: got %b want 00000000",
                {in_valid_w1, in_valid_w2, in_valid_d, in_valid_t, busy, done, res_valid, err_tout});
        end
        vectors++;
        if ({weight1, weight2, data_point, target} !== 128'd0) begin
            miscompares++; $display("FAIL reset_bus: got %h want 0", {weight1, weight2, data_point, target});
        end
        vectors++;
        if ({res_data, res_idx, 6'd0, rom_addr} !== 48'd0) begin
            miscompares++; $display("FAIL reset_res: got %h/%h/%h want 0", res_data, res_idx, rom_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] g;
        for (int i = 0; i < 12; i++) rom[i] = 32'(i);
        for (int i = 0; i < 3; i++) rom[12+i] = 32'h100 + 32'(i);
        lat_arr[0] = 10; ans_arr[0] = FP_ONE;
        run_id++; pulse_start(1); wait_done(200, "basic");
        for (int i = 0; i < 12; i++) begin
            g = (i < w1_q.size()) ? w1_q[i] : 32'hxxxx_xxxx; vectors++;
            if (g !== rom[i]) begin miscompares++; $display("FAIL basic_w1[%0d]: got %h want %h", i, g, rom[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            g = (i < w2_q.size()) ? w2_q[i] : 32'hxxxx_xxxx; vectors++;
            if (g !== rom[12+i]) begin miscompares++; $display("FAIL basic_w2[%0d]: got %h want %h", i, g, rom[12+i]); end
        end
        vectors++;
        if (w1_q.size() != 12 || w2_q.size() != 3 || w1_c[11] - w1_c[0] != 11 || w2_c[0] != w1_c[11] + 1 || w2_c[2] - w2_c[0] != 2) begin
            miscompares++; $display("FAIL basic_wgt_contig: got %0d w1 %0d w2 beats, not one 15-cycle run, want 12+3", w1_q.size(), w2_q.size());
        end
        vectors++;
        if (gap_q.size() != 1 || gap_q[0] != 1) begin
            miscompares++; $display("FAIL basic_gap: got %0d gaps (first %0d) want 1 gap of 1", gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1);
        end
        for (int i = 0; i < 4; i++) begin
            g = (i < d_q.size()) ? d_q[i] : 32'hxxxx_xxxx; vectors++;
            if (g !== rom[15+i]) begin miscompares++; $display("FAIL basic_d[%0d]: got %h want %h", i, g, rom[15+i]); end
        end
        g = (t_q.size() == 1) ? t_q[0] : 32'hxxxx_xxxx; vectors++;
        if (g !== rom[19]) begin miscompares++; $display("FAIL basic_t: got %h want %h", g, rom[19]); end
        vectors++;
        if (d_c.size() != 4 || t_c.size() != 1 || d_c[3] - d_c[0] != 3 || t_c[0] != d_c[3] + 1) begin
            miscompares++; $display("FAIL basic_dt_contig: got %0d d %0d t beats, want 4 contiguous then t", d_c.size(), t_c.size());
        end
        vectors++;
        if (rd_q.size() != 1 || rd_q[0] !== FP_ONE || ri_q[0] != 0 || rc_q[0] != t_c[0] + 11) begin
            miscompares++; $display("FAIL basic_res: got %0d results (first %h) want 1 result 3f800000 idx 0 at t+11", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
        vectors++;
        if (done_n != 1 || overlap != 0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_done: got done %0d overlap %0d busy %b want 1/0/0", done_n, overlap, busy);
        end
        vectors++;
        if (weight1 !== rom[11] || weight2 !== rom[14] || data_point !== rom[18] || target !== rom[19]) begin
            miscompares++; $display("FAIL basic_hold: got %h %h %h %h want %h %h %h %h", weight1, weight2, data_point, target, rom[11], rom[14], rom[18], rom[19]);
        end
    endtask

    task automatic test_multi(input int n, input bit rnd, input string tag);
        logic [31:0] g;
        int b;
        for (int s = 0; s < n; s++) begin
            lat_arr[s] = rnd ? int'($urandom_range(1, 40)) : 1;
            ans_arr[s] = $urandom;
        end
        run_id++; pulse_start(n); wait_done(100 + 80 * n, tag);
        vectors++;
        if (w1_q.size() != 12 || w2_q.size() != 3 || d_q.size() != 4 * n || t_q.size() != n || overlap != 0 || done_n != 1) begin
            miscompares++; $display("FAIL %s_counts: got w1 %0d w2 %0d d %0d t %0d ovl %0d done %0d want 12 3 %0d %0d 0 1",
                tag, w1_q.size(), w2_q.size(), d_q.size(), t_q.size(), overlap, done_n, 4 * n, n);
        end
        for (int s = 0; s < n; s++) begin
            b = 15 + 5 * s;
            for (int j = 0; j < 4; j++) begin
                g = (4 * s + j < d_q.size()) ? d_q[4*s+j] : 32'hxxxx_xxxx; vectors++;
                if (g !== rom[b+j]) begin miscompares++; $display("FAIL %s_d[%0d][%0d]: got %h want %h", tag, s, j, g, rom[b+j]); end
            end
            g = (s < t_q.size()) ? t_q[s] : 32'hxxxx_xxxx; vectors++;
            if (g !== rom[b+4]) begin miscompares++; $display("FAIL %s_t[%0d]: got %h want %h", tag, s, g, rom[b+4]); end
            vectors++;
            if (s >= gap_q.size() || gap_q[s] < 1 || (s == 0 && gap_q[s] != 1)) begin
                miscompares++; $display("FAIL %s_gap[%0d]: got %0d idle cycles want %s", tag, s, (s < gap_q.size()) ? gap_q[s] : -1, (s == 0) ? "1" : ">=1");
            end
            g = (s < rd_q.size()) ? rd_q[s] : 32'hxxxx_xxxx; vectors++;
            if (g !== ans_arr[s] || s >= ri_q.size() || ri_q[s] != s || s >= t_c.size() || rc_q[s] != t_c[s] + lat_arr[s] + 1) begin
                miscompares++; $display("FAIL %s_res[%0d]: got %h want %h idx %0d at t+%0d", tag, s, g, ans_arr[s], s, lat_arr[s] + 1);
            end
        end
    endtask

    task automatic test_timeout();
        for (int s = 0; s < 3; s++) lat_arr[s] = 0;
        run_id++; pulse_start(3); wait_done(600, "tout");
        vectors++;
        if (t_c.size() != 1 || err_c - t_c[0] != 255) begin
            miscompares++; $display("FAIL tout_cycle: got err at t+%0d want t+255", (t_c.size() > 0) ? err_c - t_c[0] : -1);
        end
        vectors++;
        if (d_q.size() != 4 || rd_q.size() != 0 || done_n != 1 || done_c != err_c + 1 || err_tout !== 1'b1) begin
            miscompares++; $display("FAIL tout_abort: got d %0d res %0d done %0d err %b want 4 0 1 1", d_q.size(), rd_q.size(), done_n, err_tout);
        end
        run_id++; pulse_start(0);
        vectors++;
        if (err_tout !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL tout_clear: got err %b busy %b want 0 1", err_tout, busy);
        end
        wait_done(100, "tout_clr");
    endtask

    task automatic test_lat_edge();
        lat_arr[0] = 254; ans_arr[0] = $urandom;
        run_id++; pulse_start(1); wait_done(600, "edge254");
        vectors++;
        if (rd_q.size() != 1 || rd_q[0] !== ans_arr[0] || err_c != -1 || err_tout !== 1'b0 || rc_q[0] != t_c[0] + 255) begin
            miscompares++; $display("FAIL edge254: got res %0d err %b want 1 result at t+255, err 0", rd_q.size(), err_tout);
        end
        lat_arr[0] = 255;
        run_id++; pulse_start(1); wait_done(600, "edge255");
        vectors++;
        if (rd_q.size() != 0 || t_c.size() != 1 || err_c - t_c[0] != 255) begin
            miscompares++; $display("FAIL edge255: got res %0d err at t+%0d want 0 results, err at t+255", rd_q.size(), (t_c.size() > 0) ? err_c - t_c[0] : -1);
        end
    endtask

    task automatic test_spurious();
        lat_arr[0] = 5; ans_arr[0] = 32'h4040_0000;
        spur_on = 1'b1;
        run_id++; pulse_start(1);
        repeat (2) @(negedge clk);
        pulse_start(5);
        wait_done(200, "spur");
        spur_on = 1'b0;
        vectors++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'h4040_0000 || ri_q[0] != 0) begin
            miscompares++; $display("FAIL spur_res: got %0d results (first %h) want 1 result 40400000", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
        end
        vectors++;
        if (w1_q.size() != 12 || t_q.size() != 1 || done_n != 1) begin
            miscompares++; $display("FAIL spur_restart: got w1 %0d t %0d done %0d want 12 1 1", w1_q.size(), t_q.size(), done_n);
        end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        for (int i = 0; i < 15; i++) rom[i] = $urandom | 32'h8000_0000;
        lat_arr[0] = 3; lat_arr[1] = 3;
        run_id++; pulse_start(2);
        for (int k = 0; k < 100 && nd < 2; k++) begin
            @(negedge clk);
            if (in_valid_d) nd++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_valid_w1, in_valid_w2, in_valid_d, in_valid_t, busy} !== 5'b0 || nd != 2) begin
            miscompares++; $display("FAIL rstmid_state: got %b after %0d d beats want 00000 after 2",
                {in_valid_w1, in_valid_w2, in_valid_d, in_valid_t, busy}, nd);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (done_n != 0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_nodone: got done %0d busy %b want 0 0", done_n, busy);
        end
        run_id++; pulse_start(0); wait_done(100, "rstmid");
        vectors++;
        if (w1_q.size() != 12 || w1_q[0] !== rom[0] || w1_q[11] !== rom[11]) begin
            miscompares++; $display("FAIL rstmid_replay: got %0d w1 first %h want 12 first %h", w1_q.size(), (w1_q.size() > 0) ? w1_q[0] : 32'h0, rom[0]);
        end
    endtask

    task automatic test_weights_only();
        run_id++; pulse_start(0); wait_done(100, "wonly");
        vectors++;
        if (w1_q.size() != 12 || w2_q.size() != 3 || d_q.size() != 0 || t_q.size() != 0 || rd_q.size() != 0) begin
            miscompares++; $display("FAIL wonly_beats: got w1 %0d w2 %0d d %0d t %0d res %0d want 12 3 0 0 0",
                w1_q.size(), w2_q.size(), d_q.size(), t_q.size(), rd_q.size());
        end
        vectors++;
        if (done_n != 1 || w2_c.size() != 3 || done_c <= w2_c[2] || busy !== 1'b0) begin
            miscompares++; $display("FAIL wonly_done: got done %0d at %0d busy %b want 1 after last weight beat", done_n, done_c, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        for (int i = 0; i < 16; i++) begin lat_arr[i] = 1; ans_arr[i] = 32'd0; end
        test_reset();
        test_basic();
        test_multi(3, 1'b0, "multi");
        for (int r = 0; r < 3; r++) test_multi(int'($urandom_range(1, 5)), 1'b1, "rand");
        test_timeout();
        test_lat_edge();
        test_spurious();
        test_reset_mid();
        test_weights_only();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
